// File: rtl/mul_pkg.sv
// Shared definitions for the three-stage shift-add multiplier.
// Holds the op encoding and the E/M/W multiplier-bit split points.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    localparam int MUL_XLEN = 32;
    localparam int MUL_E_LO = 0;
    localparam int MUL_M_LO = 11;
    localparam int MUL_W_LO = 22;

endpackage

// File: rtl/mul_w_accum.sv
// W-stage datapath: adds multiplier bits SPLIT_LO..XLEN-1 onto the M-stage partial
// product, restores the result sign and picks the low or high word for the op.
module mul_w_accum
    import mul_pkg::*;
#(
    parameter int XLEN     = MUL_XLEN,
    parameter int SPLIT_LO = MUL_W_LO
) (
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              neg_a,
    input  logic              neg_b,
    input  mul_op_e           op,
    input  logic [2*XLEN-1:0] M_product,
    output logic [XLEN-1:0]   result
);

    localparam int HI_W = XLEN - SPLIT_LO;

    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic [HI_W-1:0]   ma_hi;
    logic [2*XLEN-1:0] sum;
    logic [2*XLEN-1:0] p;

    // Magnitudes; a negated 0x80000000 stays 2^31, read as unsigned.
    assign ma    = neg_a ? (~rs1 + 1'b1) : rs1;
    assign mb    = neg_b ? (~rs2 + 1'b1) : rs2;
    assign ma_hi = HI_W'(ma >> SPLIT_LO);

    always_comb begin
        sum = M_product;
        for (int i = 0; i < HI_W; i++) begin
            if (ma_hi[i]) begin
                sum = sum + ({{XLEN{1'b0}}, mb} << (SPLIT_LO + i));
            end
        end
    end

    assign p = (neg_a ^ neg_b) ? (~sum + 1'b1) : sum;

    // Signedness was already folded into neg_a/neg_b, so op only picks the word.
    always_comb begin
        case (op)
            MUL:     result = p[XLEN-1:0];
            default: result = p[2*XLEN-1:XLEN];
        endcase
    end

endmodule

// File: rtl/mul_w_finish.sv
// Final multiplier stage: handshake, result register and optional retire counter.
// Optional feature macro: MUL_PERF_CNT_EN (retired-multiply counter).
module mul_w_finish
    import mul_pkg::*;
#(
    parameter int XLEN     = MUL_XLEN,
    parameter int SPLIT_LO = MUL_W_LO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              neg_a,
    input  logic              neg_b,
    input  logic [1:0]        op,
    input  logic [4:0]        rd,
    input  logic [2*XLEN-1:0] M_product,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        out_rd,
    output logic [31:0]       perf_mul_cnt
);

    logic            accept;
    logic            retire;
    logic [XLEN-1:0] next_result;

    mul_w_accum #(
        .XLEN     (XLEN),
        .SPLIT_LO (SPLIT_LO)
    ) u_accum (
        .rs1       (rs1),
        .rs2       (rs2),
        .neg_a     (neg_a),
        .neg_b     (neg_b),
        .op        (mul_op_e'(op)),
        .M_product (M_product),
        .result    (next_result)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = out_valid && out_ready;

    // Flush beats both accept and stall; a same-cycle retire is still a retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= next_result;
            out_rd    <= rd;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUL_PERF_CNT_EN
    logic [31:0] mul_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (retire) begin
            mul_cnt <= mul_cnt + 32'd1;
        end
    end

    assign perf_mul_cnt = mul_cnt;
`else
    assign perf_mul_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_w_finish.sv
// Directed bench for mul_w_finish: a model predicts each accepted result into a
// scoreboard queue, which is popped and compared as the stage retires results.
module tb_mul_w_finish;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        neg_a;
    logic        neg_b;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [63:0] M_product;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic [31:0] perf_mul_cnt;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend_exp;
    logic        model_valid;
    int unsigned model_cnt;
    int          checks;
    int          errors;

    mul_w_finish dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .neg_a        (neg_a),
        .neg_b        (neg_b),
        .op           (op),
        .rd           (rd),
        .M_product    (M_product),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_rd       (out_rd),
        .perf_mul_cnt (perf_mul_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full 64-bit multiply of the magnitudes, then sign and word select.
    function automatic logic [31:0] modelResult(input logic [1:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic na,
                                                input logic nb);
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] prod;
        ma   = {32'd0, na ? (32'd0 - a) : a};
        mb   = {32'd0, nb ? (32'd0 - b) : b};
        prod = ma * mb;
        if (na ^ nb) prod = 64'd0 - prod;
        return (o == 2'd0) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic na, input logic nb, input logic [4:0] r);
        logic [31:0] ma;
        logic [31:0] mb;
        ma        = na ? (32'd0 - a) : a;
        mb        = nb ? (32'd0 - b) : b;
        in_valid  = 1'b1;
        op        = o;
        rs1       = a;
        rs2       = b;
        neg_a     = na;
        neg_b     = nb;
        rd        = r;
        M_product = {42'd0, ma[21:0]} * {32'd0, mb};
        pend_exp  = '{rd: r, res: modelResult(o, a, b, na, nb)};
    endtask

    task automatic checkOutput();
        checkValue("out_valid", {63'd0, out_valid}, {63'd0, model_valid});
        if (model_valid && sb.size() > 0) begin
            checkValue("result", {32'd0, result}, {32'd0, sb[0].res});
            checkValue("out_rd", {59'd0, out_rd}, {59'd0, sb[0].rd});
        end
`ifdef MUL_PERF_CNT_EN
        checkValue("perf_mul_cnt", {32'd0, perf_mul_cnt}, {32'd0, model_cnt});
`else
        checkValue("perf_mul_cnt", {32'd0, perf_mul_cnt}, 64'd0);
`endif
    endtask

    // One clock from a negedge: check in_ready, advance the model, check outputs.
    task automatic tick();
        logic acc;
        logic ret;
        #1;
        checkValue("in_ready", {63'd0, in_ready}, {63'd0, (!model_valid || out_ready)});
        acc = in_valid && (!model_valid || out_ready) && !flush;
        ret = model_valid && out_ready;
        @(posedge clk);
        if (ret) begin
            if (sb.size() > 0) void'(sb.pop_front());
            model_cnt++;
        end
        if (flush) begin
            sb.delete();
            model_valid = 1'b0;
        end else if (acc) begin
            sb.push_back(pend_exp);
            model_valid = 1'b1;
        end else if (ret) begin
            model_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_valid = 1'b0;
        model_cnt   = 0;
        pend_exp    = '0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        rs1         = '0;
        rs2         = '0;
        neg_a       = 1'b0;
        neg_b       = 1'b0;
        op          = 2'd0;
        rd          = '0;
        M_product   = '0;

        repeat (2) @(negedge clk);
        #1;
        checkValue("reset out_valid", {63'd0, out_valid}, 64'd0);
        checkValue("reset result", {32'd0, result}, 64'd0);
        checkValue("reset out_rd", {59'd0, out_rd}, 64'd0);
        checkValue("reset perf_mul_cnt", {32'd0, perf_mul_cnt}, 64'd0);
        checkValue("reset in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full-throughput arithmetic vectors");
        out_ready = 1'b1;
        applyStimulus(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd1); tick();
        applyStimulus(MUL,   32'h8000_0000, 32'd2,        1'b1, 1'b0, 5'd2); tick();
        applyStimulus(MULH,  32'h8000_0000, 32'd2,        1'b1, 1'b0, 5'd3); tick();
        applyStimulus(MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd4); tick();
        applyStimulus(MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd5); tick();
        applyStimulus(MUL,   32'd0,         32'd5,        1'b1, 1'b0, 5'd6); tick();
        applyStimulus(MULHSU, 32'h1234_5678, 32'h8000_0000, 1'b0, 1'b1, 5'd7); tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'(20 + i));
            tick();
        end
        in_valid = 1'b0; tick();

        $display("[TB] stall with back-to-back requests");
        out_ready = 1'b0;
        applyStimulus(MUL,  32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 5'd8); tick();
        applyStimulus(MULH, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 5'd9); tick();
        tick();
        out_ready = 1'b1; tick();
        in_valid = 1'b0; tick();

        $display("[TB] flush while stalled");
        out_ready = 1'b0;
        applyStimulus(MUL,   32'd7, 32'd9, 1'b0, 1'b0, 5'd10); tick();
        applyStimulus(MULHU, 32'd3, 32'd4, 1'b0, 1'b0, 5'd11);
        flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; tick();
        tick();

        $display("[TB] flush coinciding with retire");
        applyStimulus(MUL,  32'd11, 32'd13, 1'b0, 1'b0, 5'd12); tick();
        out_ready = 1'b1;
        applyStimulus(MULH, 32'd17, 32'd19, 1'b0, 1'b1, 5'd13);
        flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; tick();

        $display("[TB] retires then asynchronous reset");
        applyStimulus(MUL, 32'd100, 32'd200, 1'b0, 1'b0, 5'd14); tick();
        applyStimulus(MUL, 32'd300, 32'd400, 1'b0, 1'b0, 5'd15); tick();
        applyStimulus(MUL, 32'd500, 32'd600, 1'b0, 1'b0, 5'd16); tick();
        in_valid = 1'b0; tick();
        applyStimulus(MULHU, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0, 5'd17);
        out_ready = 1'b0; tick();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_valid = 1'b0;
        model_cnt   = 0;
        checkValue("async out_valid", {63'd0, out_valid}, 64'd0);
        checkValue("async result", {32'd0, result}, 64'd0);
        checkValue("async out_rd", {59'd0, out_rd}, 64'd0);
        checkValue("async perf_mul_cnt", {32'd0, perf_mul_cnt}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 5'd18); tick();
        in_valid = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
